// File: rtl/seg_decoder_if.sv
// Seven-segment decoder bus: raw segment pattern in, decoded events out.
interface seg_decoder_if;

    // Active-low segment pattern, bit6=a .. bit0=g, asynchronous to clk
    logic [6:0] seg;
    // Last accepted character code
    logic [3:0] code;
    // One-cycle event pulses
    logic       code_valid;
    logic       unknown;
    logic       seq_hit;
    // Saturating count of decoded characters
    logic [7:0] char_count;

    // Producer of segment patterns / consumer of decode events
    modport master (
        output seg,
        input  code,
        input  code_valid,
        input  unknown,
        input  seq_hit,
        input  char_count
    );

    // Decoder side
    modport slave (
        input  seg,
        output code,
        output code_valid,
        output unknown,
        output seq_hit,
        output char_count
    );

endinterface

// File: rtl/seg_decoder.sv
// Seven-segment display decoder: synchronizes an asynchronous segment bus,
// debounces it with a stability window, decodes the accepted pattern to a
// character code and watches for the name sequence L,1,5,A.
module seg_decoder #(
    parameter int unsigned STABLE = 4
) (
    input  logic         clk,
    input  logic         reset,
    seg_decoder_if.slave bus
);

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CHAR_W  = 8;

    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'b1111111;
    localparam logic [CODE_W-1:0] CODE_1    = 4'h1;
    localparam logic [CODE_W-1:0] CODE_5    = 4'h5;
    localparam logic [CODE_W-1:0] CODE_A    = 4'hA;
    localparam logic [CODE_W-1:0] CODE_L    = 4'hB;
    localparam logic [CHAR_W-1:0] CHAR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S0    = 2'd0,
        S_L   = 2'd1,
        S_L1  = 2'd2,
        S_L15 = 2'd3
    } seq_state_e;

    // Map an active-low segment pattern to {in_table, code}
    function automatic logic [CODE_W:0] decode_seg(input logic [SEG_W-1:0] p);
        logic [CODE_W:0] r;
        r = {1'b0, CODE_W'(0)};
        case (p)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1110001: r = {1'b1, 4'hB};
            default:    r = {1'b0, CODE_W'(0)};
        endcase
        return r;
    endfunction

    // Synchronizer and stability window
    logic [SEG_W-1:0]  s1_q, s1_d;
    logic [SEG_W-1:0]  s2_q, s2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    // Decode / event registers
    logic [CODE_W-1:0] code_q, code_d;
    logic              code_valid_q, code_valid_d;
    logic              unknown_q, unknown_d;
    logic              seq_hit_q, seq_hit_d;
    logic [CHAR_W-1:0] char_count_q, char_count_d;

    // Decoded view of the synchronized pattern
    logic [CODE_W:0]   dec;
    logic              dec_hit;
    logic [CODE_W-1:0] dec_code;
    logic              is_blank;

    // Sequence detector
    seq_state_e        state_q, state_d;

    // Two-flop synchronizer, stability counter and all output registers.
    // s1/s2 reset to blank so a pattern held across reset looks like a change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q         <= SEG_BLANK;
            s2_q         <= SEG_BLANK;
            cnt_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            unknown_q    <= 1'b0;
            seq_hit_q    <= 1'b0;
            char_count_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            unknown_q    <= unknown_d;
            seq_hit_q    <= seq_hit_d;
            char_count_q <= char_count_d;
        end
    end

    // Stability window: s2 is about to take s1, so s1 != s2 means s2 changes
    // this edge and the window restarts. Accept once when the window fills.
    always_comb begin
        s1_d   = bus.seg;
        s2_d   = s1_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (s1_q != s2_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q < CNT_W'(STABLE)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == CNT_W'(STABLE - 1)) begin
                accept = 1'b1;
            end
        end
    end

    // Classify the accepted pattern: table hit, blank (ignored) or unknown
    always_comb begin
        dec          = decode_seg(s2_q);
        dec_hit      = dec[CODE_W];
        dec_code     = dec[CODE_W-1:0];
        is_blank     = (s2_q == SEG_BLANK);
        code_d       = code_q;
        code_valid_d = 1'b0;
        unknown_d    = 1'b0;
        char_count_d = char_count_q;
        if (accept) begin
            if (dec_hit) begin
                code_d       = dec_code;
                code_valid_d = 1'b1;
                if (char_count_q != CHAR_MAX) begin
                    char_count_d = char_count_q + CHAR_W'(1);
                end
            end else if (!is_blank) begin
                unknown_d = 1'b1;
            end
        end
    end

    // Sequence FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequence FSM next state: moves only on a decoded character; an unknown
    // pattern aborts, a blank leaves the state alone.
    always_comb begin
        state_d = state_q;
        if (code_valid_d) begin
            if (dec_code == CODE_L) begin
                state_d = S_L;
            end else begin
                case (state_q)
                    S_L:     state_d = (dec_code == CODE_1) ? S_L1  : S0;
                    S_L1:    state_d = (dec_code == CODE_5) ? S_L15 : S0;
                    S_L15:   state_d = S0;
                    default: state_d = S0;
                endcase
            end
        end else if (unknown_d) begin
            state_d = S0;
        end
    end

    // Sequence FSM output: hit coincides with the code_valid of the final 'A'
    always_comb begin
        seq_hit_d = 1'b0;
        if (code_valid_d && (state_q == S_L15) && (dec_code == CODE_A)) begin
            seq_hit_d = 1'b1;
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.unknown    = unknown_q;
    assign bus.seq_hit    = seq_hit_q;
    assign bus.char_count = char_count_q;

endmodule
